// File: rtl/max_reduce_stream.sv
// Pipelined signed max-reduction: per-beat lane maximum through a registered comparator
// tree, then a frame accumulator that reports {max, lane, beat} on the frame's last beat.
module max_reduce_stream #(
  parameter int DATA_WIDTH       = 18,
  parameter int NUM_IN           = 64,
  parameter int LEVELS_PER_STAGE = 3,
  parameter int BEAT_W           = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [NUM_IN-1:0]              lane_en,
  input  logic [DATA_WIDTH*NUM_IN-1:0]   in_data,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_max,
  output logic [$clog2(NUM_IN)-1:0]      out_lane,
  output logic [BEAT_W-1:0]              out_beat
);

  localparam int LANE_W = $clog2(NUM_IN);
  localparam int MAG_W  = DATA_WIDTH - 1;
  localparam int LEVELS = LANE_W;
  localparam int STAGES = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int NODES  = 2 * NUM_IN - 1;

  // Negative or disabled lanes clamp to zero so the tree can compare magnitudes unsigned.
  function automatic logic [MAG_W-1:0] clamp_leaf(input logic signed [DATA_WIDTH-1:0] x,
                                                  input logic en);
    if (!en || x[DATA_WIDTH-1]) return '0;
    return x[MAG_W-1:0];
  endfunction

  function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Heap-ordered tree: root 0, children 2i+1/2i+2, leaves NUM_IN-1.. in lane order.
  function automatic logic node_is_reg(input int idx);
    int depth;
    int lvl;
    if (idx >= NUM_IN - 1) return 1'b0;
    depth = 0;
    for (int x = idx + 1; x > 1; x = x >> 1) depth++;
    lvl = LEVELS - depth;
    return (lvl % LEVELS_PER_STAGE == 0) || (lvl == LEVELS);
  endfunction

  logic [MAG_W-1:0]  node_val    [NODES];
  logic [LANE_W-1:0] node_lane   [NODES];
  logic [MAG_W-1:0]  node_val_p  [NODES];
  logic [LANE_W-1:0] node_lane_p [NODES];
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] last_p;

  logic [BEAT_W-1:0] beat_cnt;
  logic [MAG_W-1:0]  acc_val;
  logic [LANE_W-1:0] acc_lane;
  logic [BEAT_W-1:0] acc_beat;
  logic              take;
  logic [MAG_W-1:0]  nxt_val;
  logic [LANE_W-1:0] nxt_lane;
  logic [BEAT_W-1:0] nxt_beat;

  always_comb begin
    logic [MAG_W-1:0]  a_v;
    logic [MAG_W-1:0]  b_v;
    logic [LANE_W-1:0] a_l;
    logic [LANE_W-1:0] b_l;
    a_v = '0;
    b_v = '0;
    a_l = '0;
    b_l = '0;
    node_val  = '{default: '0};
    node_lane = '{default: '0};
    for (int j = 0; j < NUM_IN; j++) begin
      node_val[NUM_IN-1+j]  = clamp_leaf(in_data[DATA_WIDTH*j +: DATA_WIDTH], lane_en[j]);
      node_lane[NUM_IN-1+j] = LANE_W'(j);
    end
    // Children always have higher indices, so a descending sweep sees them resolved.
    for (int i = NUM_IN - 2; i >= 0; i--) begin
      if (node_is_reg(2*i+1)) begin
        a_v = node_val_p[2*i+1];
        a_l = node_lane_p[2*i+1];
        b_v = node_val_p[2*i+2];
        b_l = node_lane_p[2*i+2];
      end else begin
        a_v = node_val[2*i+1];
        a_l = node_lane[2*i+1];
        b_v = node_val[2*i+2];
        b_l = node_lane[2*i+2];
      end
      if (a_v >= b_v) begin
        node_val[i]  = a_v;
        node_lane[i] = a_l;
      end else begin
        node_val[i]  = b_v;
        node_lane[i] = b_l;
      end
    end
  end

  // Tree stage registers (only the nodes on registered levels are consumed)
  always_ff @(posedge clk) begin
    node_val_p  <= node_val;
    node_lane_p <= node_lane;
    for (int k = STAGES - 1; k > 0; k--) last_p[k] <= last_p[k-1];
    last_p[0] <= in_last;
  end

  // Accumulator: a zero beat count marks the first beat of a frame, which always loads.
  always_comb begin
    take     = (beat_cnt == '0) || (node_val_p[0] > acc_val);
    nxt_val  = take ? node_val_p[0]  : acc_val;
    nxt_lane = take ? node_lane_p[0] : acc_lane;
    nxt_beat = take ? beat_cnt       : acc_beat;
  end

  // Accumulator / output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p     <= '0;
      beat_cnt  <= '0;
      acc_val   <= '0;
      acc_lane  <= '0;
      acc_beat  <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_lane  <= '0;
      out_beat  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        // Zeroing the beat count is enough to orphan the partial accumulator contents.
        vld_p    <= '0;
        beat_cnt <= '0;
      end else begin
        for (int k = STAGES - 1; k > 0; k--) vld_p[k] <= vld_p[k-1];
        vld_p[0] <= in_valid;
        if (vld_p[STAGES-1]) begin
          acc_val  <= nxt_val;
          acc_lane <= nxt_lane;
          acc_beat <= nxt_beat;
          if (last_p[STAGES-1]) begin
            out_valid <= 1'b1;
            out_max   <= {1'b0, nxt_val};
            out_lane  <= nxt_lane;
            out_beat  <= nxt_beat;
            beat_cnt  <= '0;
          end else begin
            beat_cnt <= sat_inc(beat_cnt);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_max_reduce_stream.sv
// Scoreboard bench for max_reduce_stream over four parameter sets, each with its own
// frame-level reference model, expected-result queue and monitor.
module tb_max_reduce_stream;

  localparam int DW = 18;

  typedef struct {
    int due;
    int mx;
    int lane;
    int beat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int NI       = (g == 0) ? 64 : (g == 2) ? 128 : 8;
    localparam int LP       = (g == 1 || g == 3) ? 1 : 3;
    localparam int BW       = (g == 3) ? 4 : 16;
    localparam int LW       = $clog2(NI);
    localparam int S        = (LW + LP - 1) / LP;
    localparam int BEAT_MAX = (1 << BW) - 1;

    logic            rst_n    = 1'b0;
    logic            flush    = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last  = 1'b0;
    logic [NI-1:0]   lane_en  = '0;
    logic [DW*NI-1:0] in_data = '0;
    logic            out_valid;
    logic [DW-1:0]   out_max;
    logic [LW-1:0]   out_lane;
    logic [BW-1:0]   out_beat;

    exp_t exp_q[$];
    int   m_cnt = 0;
    int   m_max = 0;
    int   m_lane = 0;
    int   m_beat = 0;
    int   h_max = 0;
    int   h_lane = 0;
    int   h_beat = 0;
    logic stim_done = 1'b0;
    logic fin = 1'b0;

    max_reduce_stream #(
      .DATA_WIDTH(DW), .NUM_IN(NI), .LEVELS_PER_STAGE(LP), .BEAT_W(BW)
    ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_last(in_last),
      .lane_en(lane_en), .in_data(in_data), .out_valid(out_valid), .out_max(out_max),
      .out_lane(out_lane), .out_beat(out_beat)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
        n_errors++;
        $display("FAIL cfg%0d %s: got %0d, expected %0d (cycle %0d)", g, name, act, req, cyc);
      end
    endfunction

    // One input cycle; the model sees exactly what the DUT is given.
    task automatic drive(input logic v, input logic l, input logic fl,
                         input logic [DW*NI-1:0] d, input logic [NI-1:0] e);
      int bmax;
      int blane;
      int vj;
      @(posedge clk);
      #1;
      in_valid = v;
      in_last  = l;
      flush    = fl;
      in_data  = d;
      lane_en  = e;
      if (fl) begin
        while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
        m_cnt = 0;
      end else if (v) begin
        bmax  = 0;
        blane = 0;
        for (int j = 0; j < NI; j++) begin
          vj = (e[j] && !d[DW*j+DW-1]) ? int'(d[DW*j +: DW]) : 0;
          if (vj > bmax) begin
            bmax  = vj;
            blane = j;
          end
        end
        if (m_cnt == 0 || bmax > m_max) begin
          m_max  = bmax;
          m_lane = blane;
          m_beat = (m_cnt > BEAT_MAX) ? BEAT_MAX : m_cnt;
        end
        m_cnt++;
        if (l) begin
          exp_q.push_back('{cyc + S + 1, m_max, m_lane, m_beat});
          m_cnt = 0;
        end
      end
    endtask

    task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_beat(output logic [DW*NI-1:0] d, output logic [NI-1:0] e,
                             input logic narrow);
      for (int j = 0; j < NI; j++) begin
        d[DW*j +: DW] = narrow ? DW'($urandom_range(0, 15)) : DW'($urandom);
        e[j] = ($urandom_range(0, 7) != 0);
      end
    endtask

    task automatic rand_frames(input int nfr, input int maxlen);
      logic [DW*NI-1:0] d;
      logic [NI-1:0]    e;
      int               len;
      logic             narrow;
      for (int f = 0; f < nfr; f++) begin
        len    = $urandom_range(1, maxlen);
        narrow = 1'($urandom_range(0, 1));
        for (int b = 0; b < len; b++) begin
          rand_beat(d, e, narrow);
          drive(1'b1, b == len - 1, $urandom_range(0, 29) == 0, d, e);
          if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
        end
      end
    endtask

    task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      #2;
      rst_n = 1'b0;
      m_cnt = 0;
      repeat (n) @(negedge clk);
      #1;
      rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
      exp_t ex;
      if (!rst_n) begin
        chk("reset_valid", 32'(out_valid), 32'(0));
        chk("reset_max", 32'(out_max), 32'(0));
        chk("reset_lane", 32'(out_lane), 32'(0));
        chk("reset_beat", 32'(out_beat), 32'(0));
        exp_q.delete();
        h_max  = 0;
        h_lane = 0;
        h_beat = 0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL cfg%0d unexpected_pulse: got out_max=%0d, expected no pulse (cycle %0d)",
                   g, out_max, cyc);
        end else begin
          ex = exp_q.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(ex.due));
          chk("out_max", 32'(out_max), 32'(ex.mx));
          chk("out_lane", 32'(out_lane), 32'(ex.lane));
          chk("out_beat", 32'(out_beat), 32'(ex.beat));
          h_max  = ex.mx;
          h_lane = ex.lane;
          h_beat = ex.beat;
        end
      end else begin
        chk("hold_max", 32'(out_max), 32'(h_max));
        chk("hold_lane", 32'(out_lane), 32'(h_lane));
        chk("hold_beat", 32'(out_beat), 32'(h_beat));
      end
      if (stim_done && !fin) begin
        chk("pending_results", 32'(exp_q.size()), 32'(0));
        fin = 1'b1;
      end
    end

    if (g == 0) begin : g_dir
      initial begin
        logic [DW*NI-1:0] d;
        logic [NI-1:0]    e;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        e = '1;
        d = '0;
        for (int j = 0; j < NI; j++) d[DW*j +: DW] = 18'd10;
        d[DW*37 +: DW] = 18'd500;
        drive(1'b1, 1'b1, 1'b0, d, e);
        d = '0;
        d[DW*3 +: DW] = 18'h3FFFF;
        d[DW*9 +: DW] = 18'h3FFFF;
        d[DW*5 +: DW] = 18'd7;
        e = '1;
        e[5] = 1'b0;
        drive(1'b1, 1'b1, 1'b0, d, e);
        e = '1;
        drive(1'b1, 1'b1, 1'b0, d, e);
        d = '0;
        d[DW*12 +: DW] = 18'd99;
        d[DW*40 +: DW] = 18'd99;
        drive(1'b1, 1'b1, 1'b0, d, e);
        d = '0;
        d[DW*20 +: DW] = 18'd50;
        drive(1'b1, 1'b0, 1'b0, d, e);
        d = '0;
        d[DW*7 +: DW] = 18'd99;
        drive(1'b1, 1'b0, 1'b0, d, e);
        d = '0;
        d[DW*2 +: DW] = 18'd99;
        drive(1'b1, 1'b1, 1'b0, d, e);
        for (int k = 1; k <= 4; k++) begin
          d = '0;
          d[DW*(k*5) +: DW] = DW'(k);
          drive(1'b1, 1'b1, 1'b0, d, e);
        end
        idle(4);
        for (int b = 0; b < 5; b++) begin
          rand_beat(d, e, 1'b1);
          drive(1'b1, b == 4, 1'b0, d, e);
        end
        for (int b = 0; b < 2; b++) begin
          rand_beat(d, e, 1'b0);
          drive(1'b1, b == 1, 1'b0, d, e);
        end
        idle(4);
        rand_beat(d, e, 1'b0);
        drive(1'b1, 1'b0, 1'b0, d, e);
        rand_beat(d, e, 1'b0);
        drive(1'b1, 1'b1, 1'b0, d, e);
        drive(1'b0, 1'b0, 1'b1, '0, '0);
        idle(5);
        for (int b = 0; b < 2; b++) begin
          rand_beat(d, e, 1'b0);
          drive(1'b1, 1'b0, 1'b0, d, e);
        end
        do_reset(2);
        idle(1);
        rand_beat(d, e, 1'b0);
        drive(1'b1, 1'b1, 1'b0, d, e);
        idle(4);
        rand_frames(60, 6);
        idle(S + 4);
        stim_done = 1'b1;
      end
    end else if (g == 3) begin : g_sat
      initial begin
        logic [DW*NI-1:0] d;
        logic [NI-1:0]    e;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        for (int b = 0; b < 19; b++) begin
          rand_beat(d, e, 1'b1);
          drive(1'b1, 1'b0, 1'b0, d, e);
        end
        d = '0;
        d[DW*6 +: DW] = 18'd1000;
        drive(1'b1, 1'b1, 1'b0, d, '1);
        idle(4);
        rand_frames(60, 20);
        idle(S + 4);
        stim_done = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rand_frames(80, 6);
        do_reset(2);
        idle(1);
        rand_frames(20, 6);
        idle(S + 4);
        stim_done = 1'b1;
      end
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && waited < 40000) begin
      @(posedge clk);
      waited++;
    end
    if (waited >= 40000) begin
      $display("FAIL timeout: got %0d cycles without completion, expected completion", waited);
      $fatal(1, "timeout");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/max_reduce_stream.md
# max_reduce_stream

Parametrised, fully pipelined signed max-reduction engine for the Smith-Waterman score path. Each cycle it reduces one beat of NUM_IN per-PE scores to a clamped maximum and the index of the lane holding it. It then accumulates across the beats of a frame, and reports the frame maximum with its lane and beat position when the frame's last beat has passed. It sits between the PE array's score outputs and the top-level result register.

## Interface
- DATA_WIDTH, 18: score width; MSB is the sign bit.
- NUM_IN, 64: lanes per beat; power of two, ≥2.
- LEVELS_PER_STAGE, 3: comparator levels between pipeline registers; ≥1.
- BEAT_W, 16: beat counter width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of pipeline and accumulator.
- in_valid  in  1  beat valid.
- in_last  in  1  last beat of frame; qualified by in_valid.
- lane_en  in  NUM_IN  per-lane enable; sampled with the beat.
- in_data  in  DATA_WIDTH*NUM_IN  lane i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- out_valid  out  1  one-cycle pulse; frame result valid.
- out_max  out  DATA_WIDTH  frame maximum, ≥0.
- out_lane  out  log2(NUM_IN)  lane of the maximum.
- out_beat  out  BEAT_W  beat index within the frame (0-based) of the maximum.

## Operation
- Leaf conditioning: a lane is forced to 0 if its sign bit is set or its lane_en bit is 0. After conditioning, every leaf is ≥0 and comparisons are unsigned on bits [DATA_WIDTH-2:0].
- Tree:
  - Binary tree of log2(NUM_IN) levels.
  - Each node forwards {value, lane index}.
  - The lower-index operand wins when values are equal (a ≥ b selects a).
  - The result is the lowest-index lane holding the maximum.
- Pipelining:
  - Registers sit after every LEVELS_PER_STAGE levels and always after the final level.
  - Stage count S = ceil(log2(NUM_IN)/LEVELS_PER_STAGE).
  - valid and last travel alongside the data.
- Accumulator:
  - The first beat of a frame always loads {max, lane, beat=0}.
  - Later beats replace the stored result only when strictly greater, so the earliest beat wins ties.
- Beat counter:
  - Increments per valid beat.
  - Saturates at 2^BEAT_W−1; it never wraps.
  - Resets to 0 after a last beat.
- Frame end: when the last beat reaches the accumulator, out_valid pulses and the outputs carry the final result including that beat. The next valid beat starts a new frame.
- Frame boundaries: a single-beat frame (in_valid & in_last) is legal. Back-to-back frames need no idle cycle.
- No backpressure: the block accepts one beat per cycle unconditionally.
- in_data, lane_en and in_last are don't-care when in_valid=0.

## Timing
- Reset: out_valid=0, out_max=0, out_lane=0, out_beat=0. All pipeline valids, the accumulator and the beat counter are cleared.
- Latency: in_valid & in_last at cycle t gives out_valid at t+S+1. With the defaults, S=2 and latency is 3.
- Throughput: 1 beat/cycle. out_valid may pulse on consecutive cycles for consecutive single-beat frames.
- Output hold: out_max, out_lane and out_beat hold their value until the next out_valid.
- flush:
  - Same-cycle effect: all in-flight valids and the partial frame are discarded. No out_valid is produced for them, and the beat counter goes to 0.
  - Output registers keep their last value.
  - A beat presented in the same cycle as flush is also discarded.
- Reset mid-frame: the partial frame is discarded; the first beat after release starts a new frame.
- Simultaneous events: out_valid for frame k and the first beat of frame k+1 entering the accumulator in the same cycle are independent.

## Test plan
- Single-beat frame, lane 37 = 500, all other lanes = 10, lane_en all 1 → out_valid at t+3; out_max=500, out_lane=37, out_beat=0.
- Negative and mask handling:
  - Lanes 3 and 9 = 0x3FFFF (negative), lane 5 = 7 with lane_en[5]=0, rest 0 → out_max=0, out_lane=0.
  - Same beat with lane_en[5]=1 → out_max=7, out_lane=5.
- Ties:
  - Lanes 12 and 40 both = 99 → out_lane=12.
  - 3-beat frame with the maximum 99 appearing in beats 1 and 2 → out_beat=1.
- Streaming:
  - 4 consecutive single-beat frames carrying maxima 1, 2, 3, 4 → out_valid high on 4 consecutive cycles with out_max 1, 2, 3, 4.
  - A 5-beat frame followed immediately by a 2-beat frame → exactly 2 pulses, each with the correct beat index.
- flush / reset:
  - Assert flush one cycle after beat 1 (last) of a 2-beat frame → no out_valid; outputs unchanged.
  - Pulse rst_n mid-frame → outputs become 0 asynchronously; the next frame reports correctly.
- Parameter sweep: NUM_IN=8, LEVELS_PER_STAGE=1 (S=3, latency 4) and NUM_IN=128, LEVELS_PER_STAGE=3 (S=3). Run random frames against a reference model, including a BEAT_W=4 case with a 20-beat frame whose maximum sits in the last beat → out_beat saturates at 15.
